// File: rtl/base12_alu_arbiter.sv
// base12_alu_arbiter: round-robin arbiter sharing one base-12 ALU among NUM_REQ requesters, with a done timeout
module base12_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_result,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    alu_enable,
  output logic [3:0]              alu_operation,
  output logic [31:0]             alu_operand_a,
  output logic [31:0]             alu_operand_b,
  input  logic [31:0]             alu_result,
  input  logic                    alu_done
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_grant, owner, gnt_idx;
  logic gnt_any;
  logic timeout_hit;
  logic [7:0] cnt;
  logic [3:0] op_arr [NUM_REQ];
  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];
  int j;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign op_arr[i] = req_op[4*i +: 4];
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end
  assign timeout_hit = cnt == 8'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign alu_enable = state == ISSUE;
  // req_ready is gated by reset_n so nothing is offered while reset is held
  assign req_ready = (reset_n && state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_idx : '0;
  assign resp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
  // round-robin search starting one past the last granted requester
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req_valid[IW'(j)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
  // next-state: grant, wait for done or timeout, hold response until owner accepts
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = gnt_any ? ISSUE : IDLE;
      ISSUE:   state_nx = (alu_done || timeout_hit) ? RESP : ISSUE;
      RESP:    state_nx = resp_ready[owner] ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // operation latch on grant, timeout counting and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IW'(NUM_REQ - 1);
      owner <= '0;
      cnt <= '0;
      alu_operation <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      resp_result <= '0;
      resp_err <= 1'b0;
    end else if (state == IDLE && gnt_any) begin
      last_grant <= gnt_idx;
      owner <= gnt_idx;
      cnt <= '0;
      alu_operation <= op_arr[gnt_idx];
      alu_operand_a <= a_arr[gnt_idx];
      alu_operand_b <= b_arr[gnt_idx];
    end else if (state == ISSUE) begin
      if (alu_done) begin
        resp_result <= alu_result;
        resp_err <= 1'b0;
      end else if (timeout_hit) begin
        resp_result <= 32'hFFFF_FFFF;
        resp_err <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_base12_alu_arbiter.sv
// tb_base12_alu_arbiter: directed vector table plus hand-written contention, timeout, backpressure and reset sequences
module tb_base12_alu_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] resp_ready = '0;
  logic [N-1:0] req_ready, resp_valid;
  logic [4*N-1:0] req_op = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [31:0] resp_result, alu_operand_a, alu_operand_b;
  logic [31:0] alu_result = '0;
  logic resp_err, busy, alu_enable;
  logic alu_done = 1'b0;
  logic [3:0] alu_operation;
  int pass_cnt = 0;
  int total = 0;
  bit hang = 1'b0;
  int lat = 2;
  int acnt = 0;

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t v [6];

  base12_alu_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_err(resp_err),
    .busy(busy), .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  // external ALU model: 0 ADD, 1 SUB, 2 MUL, 3 DIV, anything else returns 0
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b == 0) ? 32'd0 : a / b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!alu_enable) begin
      alu_done <= 1'b0;
      acnt <= 0;
    end else if (!alu_done && !hang) begin
      acnt <= acnt + 1;
      if (acnt + 1 >= lat) begin
        alu_done <= 1'b1;
        alu_result <= alu_f(alu_operation, alu_operand_a, alu_operand_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_resp(input string nm);
    int n;
    for (n = 0; n < 40 && resp_valid == '0; n++) @(negedge clk);
    chk({nm, " resp_wait"}, 32'(n < 40), 32'd1);
  endtask

  // single transaction issued at a negedge with the response accepted at once
  task automatic txn(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input string nm);
    set_req(i, op, a, b);
    req_valid = N'(1) << i;
    resp_ready = '1;
    #1;
    chk({nm, " req_ready"}, 32'(req_ready), 32'(N'(1) << i));
    @(negedge clk);
    req_valid = '0;
    chk({nm, " alu_enable"}, 32'(alu_enable), 32'd1);
    chk({nm, " alu_operation"}, 32'(alu_operation), 32'(op));
    chk({nm, " alu_operand_a"}, alu_operand_a, a);
    chk({nm, " alu_operand_b"}, alu_operand_b, b);
    chk({nm, " ready_in_issue"}, 32'(req_ready), 32'd0);
    wait_resp(nm);
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'(N'(1) << i));
    chk({nm, " resp_result"}, resp_result, er);
    chk({nm, " resp_err"}, 32'(resp_err), 32'd0);
    chk({nm, " enable_low_after_done"}, 32'(alu_enable), 32'd0);
    @(negedge clk);
    chk({nm, " back_to_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants [$];
    int nres;
    int cnt;
    bit ok;
    v[0] = '{0, 4'd0, 32'd7, 32'd5, 32'd12};
    v[1] = '{1, 4'd2, 32'd6, 32'd12, 32'd72};
    v[2] = '{3, 4'd12, 32'd9, 32'd3, 32'd0};
    v[3] = '{2, 4'd1, 32'd100, 32'd1, 32'd99};
    v[4] = '{3, 4'd3, 32'd144, 32'd12, 32'd12};
    v[5] = '{0, 4'd15, 32'd5, 32'd5, 32'd0};

    req_valid = '1;
    #2;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_result", resp_result, 32'd0);
    chk("rst alu_enable", 32'(alu_enable), 32'd0);
    chk("rst alu_operation", 32'(alu_operation), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      lat = 1 + (k % 3);
      txn(v[k].idx, v[k].op, v[k].a, v[k].b, v[k].res, $sformatf("vec%0d", k));
    end

    // contention after reset: expect grants 0,1,2,3,0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 4'd3, 32'd144, 32'd12);
    req_valid = '1;
    resp_ready = '1;
    nres = 0;
    ok = 1'b1;
    #1;
    for (int n = 0; n < 200 && (grants.size() < 5 || nres < 5); n++) begin
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) ok = 1'b0;
        for (int b = 0; b < N; b++) if (req_ready[b]) grants.push_back(b);
      end
      if (resp_valid != '0 && nres < 5) begin
        chk($sformatf("cont result%0d", nres), resp_result, 32'd12);
        nres++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("cont onehot", 32'(ok), 32'd1);
    chk("cont grant_count", 32'(grants.size() >= 5), 32'd1);
    for (int g = 0; g < 5; g++)
      chk($sformatf("cont grant%0d", g), (g < grants.size()) ? 32'(grants[g]) : 32'hDEAD, 32'(g % 4));
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);

    // timeout with a silent ALU
    hang = 1'b1;
    set_req(0, 4'd0, 32'd1, 32'd1);
    req_valid = 4'b0001;
    resp_ready = '0;
    @(negedge clk);
    req_valid = '0;
    cnt = 0;
    while (busy && resp_valid == '0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("to issue_cycles", 32'(cnt), 32'd15);
    chk("to resp_valid", 32'(resp_valid), 32'd1);
    chk("to resp_result", resp_result, 32'hFFFF_FFFF);
    chk("to resp_err", 32'(resp_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("to busy_held", 32'(busy), 32'd1);
    chk("to valid_held", 32'(resp_valid), 32'd1);
    resp_ready = '1;
    @(negedge clk);
    chk("to idle", 32'(busy), 32'd0);
    hang = 1'b0;

    // backpressure on requester 1 while non-owners accept and req0 waits
    lat = 2;
    set_req(1, 4'd2, 32'd6, 32'd12);
    set_req(0, 4'd0, 32'd1, 32'd2);
    req_valid = 4'b0010;
    resp_ready = 4'b1101;
    #1;
    chk("bp grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_resp("bp");
    ok = 1'b1;
    repeat (10) begin
      if (resp_valid != 4'b0010 || resp_result != 32'd72 || req_ready != '0 || !busy || alu_enable) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp stable", 32'(ok), 32'd1);
    chk("bp resp_result", resp_result, 32'd72);
    resp_ready = '1;
    @(negedge clk);
    chk("bp next_grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_resp("bp2");
    chk("bp2 resp_result", resp_result, 32'd3);
    @(negedge clk);

    // reset in the middle of ISSUE
    hang = 1'b1;
    set_req(0, 4'd0, 32'd5, 32'd6);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mid busy_before", 32'(busy), 32'd1);
    req_valid = '1;
    reset_n = 1'b0;
    #1;
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid alu_enable", 32'(alu_enable), 32'd0);
    chk("mid alu_operation", 32'(alu_operation), 32'd0);
    chk("mid operands", alu_operand_a | alu_operand_b, 32'd0);
    chk("mid req_ready", 32'(req_ready), 32'd0);
    chk("mid resp_valid", 32'(resp_valid), 32'd0);
    chk("mid resp_result", resp_result, 32'd0);
    chk("mid resp_err", 32'(resp_err), 32'd0);
    hang = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_req(2, 4'd1, 32'd9, 32'd4);
    req_valid = 4'b0100;
    #1;
    chk("mid grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_resp("mid2");
    chk("mid2 resp_valid", 32'(resp_valid), 32'b0100);
    chk("mid2 resp_result", resp_result, 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/base12_alu_arbiter.md
BASE12_ALU_ARBITER -- requirements
Module: base12_alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles to wait for alu_done before aborting (1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester operation request.
REQ-006 SHALL have port req_ready, output, NUM_REQ, one-hot grant/accept.
REQ-007 SHALL have port req_op, input, 4*NUM_REQ, per-requester ALU opcode; slice i is [4i+3:4i].
REQ-008 SHALL have port req_a, input, 32*NUM_REQ, per-requester operand A.
REQ-009 SHALL have port req_b, input, 32*NUM_REQ, per-requester operand B.
REQ-010 SHALL have port resp_valid, output, NUM_REQ, one-hot response valid.
REQ-011 SHALL have port resp_ready, input, NUM_REQ, per-requester response accept.
REQ-012 SHALL have port resp_result, output, 32, result for the requester flagged in resp_valid.
REQ-013 SHALL have port resp_err, output, 1, timeout flag qualified by resp_valid.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have ports alu_enable (output, 1), alu_operation (output, 4), alu_operand_a (output, 32), alu_operand_b (output, 32) driving the base-12 ALU.
REQ-016 SHALL have ports alu_result (input, 32) and alu_done (input, 1) from the base-12 ALU.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP; one ALU operation in flight at a time.
REQ-018 IDLE: if any req_valid, SHALL assert req_ready combinationally for exactly one requester chosen round-robin, starting search at index (last_grant+1) mod NUM_REQ.
REQ-019 On req_valid[i]&req_ready[i], SHALL register op/a/b of requester i into alu_operation/alu_operand_a/alu_operand_b, record i as owner and last_grant, clear timeout counter, go to ISSUE.
REQ-020 ISSUE: alu_enable SHALL be 1; alu_operation/operands SHALL remain stable; req_ready SHALL be all 0.
REQ-021 ISSUE: when alu_done sampled 1, SHALL capture alu_result, resp_err=0, drop alu_enable next cycle, go to RESP.
REQ-022 ISSUE: timeout counter SHALL increment each cycle alu_done=0; when it reaches TIMEOUT, SHALL capture resp_result=32'hFFFFFFFF, resp_err=1, go to RESP.
REQ-023 RESP: alu_enable SHALL be 0 (guarantees ALU done/cycle counter clear before next issue); resp_valid SHALL be one-hot at owner index, resp_result/resp_err stable.
REQ-024 RESP: SHALL hold until resp_ready[owner]=1, then deassert resp_valid and return to IDLE; resp_ready of non-owners SHALL be ignored.
REQ-025 Minimum gap: at least one IDLE cycle with alu_enable=0 SHALL separate consecutive ALU operations.
REQ-026 req_valid dropping during ISSUE/RESP SHALL not affect the operation in flight.
REQ-027 Opcodes 9..15 SHALL be forwarded unmodified; ALU's result (0) SHALL be returned with resp_err=0.
REQ-028 Requester with req_valid held continuously SHALL be granted within NUM_REQ grants (no starvation).

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, last_grant=NUM_REQ-1 (so index 0 wins first), req_ready=0, resp_valid=0, resp_result=0, resp_err=0, busy=0, alu_enable=0, alu_operation=0, alu_operands=0, timeout counter=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no response; the aborted requester SHALL re-request.

Verification
REQ-031 Single ADD: req0 op=0 a=7 b=5, resp_ready=1 -> resp_valid=0001, resp_result=12, resp_err=0, alu_enable low the cycle after alu_done.
REQ-032 Contention: all four request DIV a=144 b=12 continuously after reset -> grants in order 0,1,2,3,0, each resp_result=12.
REQ-033 Timeout: ALU model holds alu_done=0, TIMEOUT=15 -> after 15 ISSUE cycles resp_result=FFFFFFFF, resp_err=1, busy stays 1 until resp_ready.
REQ-034 Backpressure: req1 MUL a=6 b=12, resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_result=72 held stable, no new grant until accepted.
REQ-035 Reset mid-ISSUE: reset_n low during ISSUE -> all outputs per REQ-029 immediately; after release req2 alone -> granted first.
REQ-036 Illegal opcode: req3 op=12 -> resp_result=0, resp_err=0, FSM returns to IDLE.
